mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Iterative multiply/divide unit with HI/LO registers for the MIPS datapath. Sits beside the ALU.
- Decodes {ALUOp, ALUFunction} the same way ALU control does: R-type is ALUOp = 3'b111.
- Runs MULT/MULTU/DIV/DIVU over several cycles and serves MFHI/MFLO/MTHI/MTLO.
- Raises Stall toward the hazard logic while a result is pending.

Parameters:
- DATA_WIDTH, 32, operand/HI/LO width; even, >= 4.
- CNT_WIDTH, $clog2(DATA_WIDTH), iteration counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- Start  input  1  instruction valid this cycle
- ALUOp  input  3  from control unit
- ALUFunction  input  6  instruction funct field
- OperandA  input  DATA_WIDTH  rs value
- OperandB  input  DATA_WIDTH  rt value
- HiLoData  output  DATA_WIDTH  HI (MFHI) or LO (MFLO), combinational
- Busy  output  1  operation in progress
- Stall  output  1  request cannot be accepted this cycle, combinational
- Done  output  1  one-cycle pulse: HI/LO just updated by MULT/DIV
- DivByZero  output  1  one-cycle pulse, with Done, for DIV/DIVU with OperandB == 0

Behaviour:
- Decode (ALUOp = 111) by funct:
  - MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011
  - MULT 011000, MULTU 011001, DIV 011010, DIVU 011011
  - Any other code: no effect, no Stall.
- Reset: state IDLE; HI = LO = 0; Busy = Done = DivByZero = 0; counter = 0.
- States:
  - IDLE: Start with MULT/DIV-type, no Stall -> latch operands.
    - Divisor of 0 -> FIX.
    - Otherwise -> CALC; counter = DATA_WIDTH-1.
  - CALC: one shift-add (mult) or restoring shift-subtract (div) step per edge. Counter decrements; at counter == 0 -> FIX.
  - FIX: apply sign correction, write HI/LO, set Done (and DivByZero if applicable) for the next cycle -> IDLE.
- Busy = (state != IDLE).
- Latency: issue at edge 0; HI/LO hold the result after edge DATA_WIDTH+1 (33 cycles at 32 bits). Done is high the cycle after that edge.
- Divide by zero: result after edge 1. HI = dividend; LO = all ones; DivByZero = 1 with Done.
- Signed operations (MULT/DIV) use magnitudes, then correct:
  - product sign = sign A xor sign B
  - quotient sign = sign A xor sign B
  - remainder sign = dividend sign
- Arithmetic results:
  - MULT: HI:LO = full 2*DATA_WIDTH product.
  - DIV/DIVU: LO = quotient, HI = remainder.
  - DIV of most-negative by -1: LO = most-negative (wraps), HI = 0, no flag.
- MT*: when not Busy, HI or LO <= OperandA at the edge; single-cycle.
- MF*: HiLoData = HI or LO. For other funct codes it still shows LO.
- Stall = Start & Busy & (funct is any HI/LO instruction). The stalled request is ignored, and the upstream re-presents it.
- Start with MULT/DIV in the same cycle Done is high is accepted, because state is IDLE.
- Reset asserted mid-operation aborts immediately: HI/LO = 0, no Done.
- Operands are latched at issue; input changes during CALC have no effect.

Optional Feature:
- Macro: MULT_DIV_MADD_EN
- When defined:
  - SPECIAL2 ops are decoded with ALUOp = 3'b011: MADD funct 000000 (signed), MADDU 000001 (unsigned).
  - They run the multiply path; in FIX, HI:LO <= HI:LO + product, modulo 2^(2*DATA_WIDTH).
  - Same latency, Stall and Done rules as MULT.
- When not defined: ALUOp = 011 codes have no effect; no Stall, no state change.

Test Plan:
1. reset; MULT A=0xFFFFFFFD (-3), B=7 -> Busy for 33 cycles, Done pulse; MFHI = 0xFFFFFFFF, MFLO = 0xFFFFFFEB.
2. MULTU A=B=0xFFFFFFFF -> HI = 0xFFFFFFFE, LO = 0x00000001. DIVU 100/7 -> LO = 0x0000000E, HI = 0x00000002.
3. DIV A=0xFFFFFFF9 (-7), B=2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0.
4. DIV A=0x1234, B=0 -> Done and DivByZero high the cycle after edge 1; HI = 0x1234, LO = 0xFFFFFFFF.
5. During MULT: MFLO, MTHI, second MULT with Start=1 -> Stall=1 each time, HI/LO unchanged. After Done: MTHI 0xABCD -> MFHI = 0xABCD next cycle.
6. Reset pulse at cycle 10 of DIV -> Busy=0, HI=LO=0, no Done. With MULT_DIV_MADD_EN: HI:LO = 0:5, MADD 2*3 -> LO = 0x0000000B, HI = 0.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and MF*/MT* access.
// Optional MADD/MADDU (SPECIAL2, ALUOp 011) is enabled by defining MULT_DIV_MADD_EN.
module mult_div_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Start,
  input  logic [2:0]            ALUOp,
  input  logic [5:0]            ALUFunction,
  input  logic [DATA_WIDTH-1:0] OperandA,
  input  logic [DATA_WIDTH-1:0] OperandB,
  output logic [DATA_WIDTH-1:0] HiLoData,
  output logic                  Busy,
  output logic                  Stall,
  output logic                  Done,
  output logic                  DivByZero
);

  localparam logic [5:0] F_MFHI = 6'b010000;
  localparam logic [5:0] F_MTHI = 6'b010001;
  localparam logic [5:0] F_MTLO = 6'b010011;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t                  state;
  logic [DATA_WIDTH-1:0]   hi, lo;
  logic [DATA_WIDTH-1:0]   acc, q, m;
  logic [CNT_WIDTH-1:0]    cnt;
  logic                    is_div, is_madd, div_zero, neg_res, neg_rem;

  logic                    r_type, is_hilo, is_md, op_madd, op_div, op_signed;
  logic                    sa, sb;
  logic [DATA_WIDTH-1:0]   mag_a, mag_b;
  logic [DATA_WIDTH:0]     mul_sum;
  logic [DATA_WIDTH+1:0]   div_diff;
  logic                    div_ok;
  logic [2*DATA_WIDTH-1:0] prod, hilo_sum;
  logic [DATA_WIDTH-1:0]   quot, rem;

  always_comb begin
    r_type  = (ALUOp == 3'b111);
    is_hilo = r_type && (ALUFunction[5:2] == 4'b0100);
    is_md   = r_type && (ALUFunction[5:2] == 4'b0110);
`ifdef MULT_DIV_MADD_EN
    op_madd = (ALUOp == 3'b011) && (ALUFunction[5:1] == 5'b00000);
`else
    op_madd = 1'b0;
`endif
    op_div    = is_md && ALUFunction[1];
    op_signed = ~ALUFunction[0];
    sa        = op_signed & OperandA[DATA_WIDTH-1];
    sb        = op_signed & OperandB[DATA_WIDTH-1];
    mag_a     = sa ? -OperandA : OperandA;
    mag_b     = sb ? -OperandB : OperandB;

    Busy     = (state != IDLE);
    Stall    = Start && Busy && (is_hilo || is_md || op_madd);
    HiLoData = (r_type && (ALUFunction == F_MFHI)) ? hi : lo;

    // Multiply: {acc,q} shifts right as partial product; divide: {acc,q} shifts left.
    mul_sum  = {1'b0, acc} + (q[0] ? {1'b0, m} : '0);
    div_diff = {1'b0, acc, q[DATA_WIDTH-1]} - {2'b00, m};
    div_ok   = ~div_diff[DATA_WIDTH+1];

    prod     = neg_res ? -{acc, q} : {acc, q};
    hilo_sum = {hi, lo} + prod;
    quot     = neg_res ? -q : q;
    rem      = neg_rem ? -acc : acc;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      hi        <= '0;
      lo        <= '0;
      acc       <= '0;
      q         <= '0;
      m         <= '0;
      cnt       <= '0;
      is_div    <= 1'b0;
      is_madd   <= 1'b0;
      div_zero  <= 1'b0;
      neg_res   <= 1'b0;
      neg_rem   <= 1'b0;
      Done      <= 1'b0;
      DivByZero <= 1'b0;
    end else begin
      Done      <= 1'b0;
      DivByZero <= 1'b0;
      case (state)
        IDLE: begin
          if (Start && (is_md || op_madd)) begin
            is_div  <= op_div;
            is_madd <= op_madd;
            neg_res <= sa ^ sb;
            neg_rem <= sa;
            if (op_div && (OperandB == '0)) begin
              div_zero <= 1'b1;
              acc      <= OperandA;
              state    <= FIX;
            end else begin
              div_zero <= 1'b0;
              acc      <= '0;
              q        <= op_div ? mag_a : mag_b;
              m        <= op_div ? mag_b : mag_a;
              cnt      <= CNT_WIDTH'(DATA_WIDTH - 1);
              state    <= CALC;
            end
          end else if (Start && r_type && (ALUFunction == F_MTHI)) begin
            hi <= OperandA;
          end else if (Start && r_type && (ALUFunction == F_MTLO)) begin
            lo <= OperandA;
          end
        end
        CALC: begin
          if (is_div) begin
            acc <= div_ok ? div_diff[DATA_WIDTH-1:0] : {acc[DATA_WIDTH-2:0], q[DATA_WIDTH-1]};
            q   <= {q[DATA_WIDTH-2:0], div_ok};
          end else begin
            acc <= mul_sum[DATA_WIDTH:1];
            q   <= {mul_sum[0], q[DATA_WIDTH-1:1]};
          end
          cnt <= cnt - 1'b1;
          if (cnt == '0) state <= FIX;
        end
        FIX: begin
          if (div_zero) begin
            hi        <= acc;
            lo        <= '1;
            DivByZero <= 1'b1;
          end else if (is_div) begin
            hi <= rem;
            lo <= quot;
          end else if (is_madd) begin
            {hi, lo} <= hilo_sum;
          end else begin
            {hi, lo} <= prod;
          end
          Done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit (32-bit), immediate-assertion style.
module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic        Start;
  logic [2:0]  ALUOp;
  logic [5:0]  ALUFunction;
  logic [31:0] OperandA, OperandB;
  logic [31:0] HiLoData;
  logic        Busy, Stall, Done, DivByZero;

  int checks   = 0;
  int failures = 0;

  localparam logic [5:0] MFHI = 6'b010000, MTHI = 6'b010001, MFLO = 6'b010010, MTLO = 6'b010011;
  localparam logic [5:0] MULT = 6'b011000, MULTU = 6'b011001, DIV = 6'b011010, DIVU = 6'b011011;

  mult_div_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .Start(Start), .ALUOp(ALUOp), .ALUFunction(ALUFunction),
    .OperandA(OperandA), .OperandB(OperandB), .HiLoData(HiLoData),
    .Busy(Busy), .Stall(Stall), .Done(Done), .DivByZero(DivByZero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic read_hilo(input string tag, input logic sel_hi, input logic [31:0] exp);
    Start       = 1'b0;
    ALUOp       = 3'b111;
    ALUFunction = sel_hi ? MFHI : MFLO;
    #1;
    chk(tag, HiLoData, exp);
  endtask

  task automatic issue(input logic [2:0] op, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b);
    Start       = 1'b1;
    ALUOp       = op;
    ALUFunction = fn;
    OperandA    = a;
    OperandB    = b;
    @(negedge clk);
    Start       = 1'b0;
    ALUOp       = 3'b000;
    ALUFunction = 6'b000000;
  endtask

  task automatic wait_done(input string tag, input int exp_busy, input logic exp_dz);
    int n = 0;
    while (Busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk({tag, " busy_cycles"}, 32'(n), 32'(exp_busy));
    chk({tag, " done"}, 32'(Done), 32'd1);
    chk({tag, " div_by_zero"}, 32'(DivByZero), 32'(exp_dz));
  endtask

  initial begin
    bit seen_done;
    reset = 1'b1; Start = 1'b0; ALUOp = '0; ALUFunction = '0; OperandA = '0; OperandB = '0;
    repeat (2) @(negedge clk);
    chk("rst busy", 32'(Busy), 32'd0);
    chk("rst done", 32'(Done), 32'd0);
    chk("rst dbz", 32'(DivByZero), 32'd0);
    read_hilo("rst hi", 1'b1, 32'h0);
    read_hilo("rst lo", 1'b0, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // MULT -3 * 7 = -21
    issue(3'b111, MULT, 32'hFFFFFFFD, 32'd7);
    wait_done("mult", 33, 1'b0);
    read_hilo("mult hi", 1'b1, 32'hFFFFFFFF);
    read_hilo("mult lo", 1'b0, 32'hFFFFFFEB);
    @(negedge clk);
    chk("done pulse", 32'(Done), 32'd0);

    // MULTU max*max, then DIVU issued in the cycle Done is high
    issue(3'b111, MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done("multu", 33, 1'b0);
    read_hilo("multu hi", 1'b1, 32'hFFFFFFFE);
    read_hilo("multu lo", 1'b0, 32'h00000001);
    issue(3'b111, DIVU, 32'd100, 32'd7);
    wait_done("divu", 33, 1'b0);
    read_hilo("divu lo", 1'b0, 32'h0000000E);
    read_hilo("divu hi", 1'b1, 32'h00000002);

    // signed divides
    issue(3'b111, DIV, 32'hFFFFFFF9, 32'd2);
    wait_done("div neg", 33, 1'b0);
    read_hilo("div neg lo", 1'b0, 32'hFFFFFFFD);
    read_hilo("div neg hi", 1'b1, 32'hFFFFFFFF);
    issue(3'b111, DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_done("div ovf", 33, 1'b0);
    read_hilo("div ovf lo", 1'b0, 32'h80000000);
    read_hilo("div ovf hi", 1'b1, 32'h00000000);

    // divide by zero
    issue(3'b111, DIV, 32'h00001234, 32'd0);
    wait_done("dbz", 1, 1'b1);
    read_hilo("dbz hi", 1'b1, 32'h00001234);
    read_hilo("dbz lo", 1'b0, 32'hFFFFFFFF);

    // stalls while busy
    issue(3'b111, MULT, 32'd5, 32'd6);
    Start = 1'b1; ALUOp = 3'b111; ALUFunction = MFLO; #1;
    chk("stall mflo", 32'(Stall), 32'd1);
    @(negedge clk);
    ALUFunction = MTHI; OperandA = 32'hDEAD; #1;
    chk("stall mthi", 32'(Stall), 32'd1);
    @(negedge clk);
    ALUFunction = MULT; OperandA = 32'd9; OperandB = 32'd9; #1;
    chk("stall mult", 32'(Stall), 32'd1);
    @(negedge clk);
    ALUFunction = 6'b100000; #1;
    chk("no stall add", 32'(Stall), 32'd0);
`ifndef MULT_DIV_MADD_EN
    ALUOp = 3'b011; ALUFunction = 6'b000000; #1;
    chk("no stall special2", 32'(Stall), 32'd0);
`endif
    Start = 1'b0; ALUOp = 3'b000; ALUFunction = 6'b000000;
    wait_done("mult stalled", 30, 1'b0);
    read_hilo("stalled hi", 1'b1, 32'h00000000);
    read_hilo("stalled lo", 1'b0, 32'h0000001E);
    @(negedge clk);
    issue(3'b111, MTHI, 32'h0000ABCD, 32'd0);
    read_hilo("mthi hi", 1'b1, 32'h0000ABCD);
    read_hilo("mthi lo", 1'b0, 32'h0000001E);
    @(negedge clk);

    // reset mid-divide
    issue(3'b111, DIV, 32'd1000, 32'd3);
    repeat (10) @(negedge clk);
    reset = 1'b1; #1;
    chk("abort busy", 32'(Busy), 32'd0);
    chk("abort done", 32'(Done), 32'd0);
    read_hilo("abort hi", 1'b1, 32'h0);
    read_hilo("abort lo", 1'b0, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (Done) seen_done = 1'b1;
    end
    chk("abort no done", 32'(seen_done), 32'd0);
    chk("abort idle", 32'(Busy), 32'd0);

`ifdef MULT_DIV_MADD_EN
    issue(3'b111, MTLO, 32'd5, 32'd0);
    issue(3'b111, MTHI, 32'd0, 32'd0);
    issue(3'b011, 6'b000000, 32'd2, 32'd3);
    wait_done("madd", 33, 1'b0);
    read_hilo("madd lo", 1'b0, 32'h0000000B);
    read_hilo("madd hi", 1'b1, 32'h00000000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
